// File: rtl/gpu_clock_divider_multi_if.sv
// Control/write-port/clock-output bundle for gpu_clock_divider_multi.
// The tick vector exists only when GPU_CLKDIV_TICK_EN is defined.
interface gpu_clock_divider_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    ch_en;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [DIV_WIDTH-1:0] wr_div;
  logic                 wr_err;
  logic [NUM_CH-1:0]    div_pending;
  logic [NUM_CH-1:0]    clk_out;
`ifdef GPU_CLKDIV_TICK_EN
  logic [NUM_CH-1:0]    tick;

  modport master (output ch_en, wr_en, wr_ch, wr_div,
                  input  wr_err, div_pending, clk_out, tick);
  modport slave  (input  ch_en, wr_en, wr_ch, wr_div,
                  output wr_err, div_pending, clk_out, tick);
`else
  modport master (output ch_en, wr_en, wr_ch, wr_div,
                  input  wr_err, div_pending, clk_out);
  modport slave  (input  ch_en, wr_en, wr_ch, wr_div,
                  output wr_err, div_pending, clk_out);
`endif
endinterface

// File: rtl/gpu_clock_divider_multi.sv
// NUM_CH runtime-programmable clock dividers with glitch-free enable and boundary-aligned divisor updates.
// Define GPU_CLKDIV_TICK_EN to add a registered one-cycle tick per channel at each clk_out rise.
module gpu_clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  gpu_clock_divider_multi_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO      = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] RST_DIV  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [CH_W:0]        CH_LIMIT = (CH_W+1)'(NUM_CH);

  if (NUM_CH < 1 || DIV_WIDTH < 2 || DEFAULT_DIV < 2 || DEFAULT_DIV > (2**DIV_WIDTH) - 1) begin : g_bad_cfg
    $fatal(1, "gpu_clock_divider_multi: illegal NUM_CH/DIV_WIDTH/DEFAULT_DIV");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

  state_t               state     [NUM_CH];
  state_t               state_nxt [NUM_CH];
  logic [DIV_WIDTH-1:0] count     [NUM_CH];
  logic [DIV_WIDTH-1:0] count_nxt [NUM_CH];
  logic [DIV_WIDTH-1:0] div       [NUM_CH];
  logic [DIV_WIDTH-1:0] div_nxt   [NUM_CH];
  logic [DIV_WIDTH-1:0] pend_div     [NUM_CH];
  logic [DIV_WIDTH-1:0] pend_div_nxt [NUM_CH];
  logic [NUM_CH-1:0]    boundary, rise, wr_hit;
  logic [NUM_CH-1:0]    pending, pending_nxt, clk_q, clk_nxt;
  logic                 wr_bad, wr_err_q;

  always_comb begin
    wr_bad = bus.wr_en && ((bus.wr_div < TWO) || ({1'b0, bus.wr_ch} >= CH_LIMIT));
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i]   = bus.wr_en && !wr_bad && (bus.wr_ch == CH_W'(i));
      boundary[i] = (state[i] != IDLE) && (count[i] == div[i] - ONE);
      rise[i]     = (state[i] != IDLE) && (count[i] == (div[i] >> 1) - ONE);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= state_nxt[i];
    end
  end

  // STOPPING keeps counting so a disable never truncates the current period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE:     if (bus.ch_en[i]) state_nxt[i] = RUN;
        RUN:      if (!bus.ch_en[i]) state_nxt[i] = boundary[i] ? IDLE : STOPPING;
        STOPPING: begin
          if (bus.ch_en[i])     state_nxt[i] = RUN;
          else if (boundary[i]) state_nxt[i] = IDLE;
        end
        default:  state_nxt[i] = IDLE;
      endcase
    end
  end

  // A write landing on the boundary cycle bypasses pend_div and overrides any older pending value.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      count_nxt[i]    = (state[i] == IDLE || boundary[i]) ? '0 : count[i] + ONE;
      if (state[i] == IDLE || boundary[i]) clk_nxt[i] = 1'b0;
      else if (rise[i])                    clk_nxt[i] = 1'b1;
      else                                 clk_nxt[i] = clk_q[i];
      div_nxt[i]      = div[i];
      pend_div_nxt[i] = pend_div[i];
      pending_nxt[i]  = pending[i];
      if (boundary[i] && pending[i]) begin
        div_nxt[i]     = pend_div[i];
        pending_nxt[i] = 1'b0;
      end
      if (wr_hit[i]) begin
        if (state[i] == IDLE || boundary[i]) begin
          div_nxt[i]     = bus.wr_div;
          pending_nxt[i] = 1'b0;
        end else begin
          pend_div_nxt[i] = bus.wr_div;
          pending_nxt[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]    <= '0;
        div[i]      <= RST_DIV;
        pend_div[i] <= RST_DIV;
      end
      pending  <= '0;
      clk_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]    <= count_nxt[i];
        div[i]      <= div_nxt[i];
        pend_div[i] <= pend_div_nxt[i];
      end
      pending  <= pending_nxt;
      clk_q    <= clk_nxt;
      wr_err_q <= wr_bad;
    end
  end

  assign bus.wr_err      = wr_err_q;
  assign bus.div_pending = pending;
  assign bus.clk_out     = clk_q;

`ifdef GPU_CLKDIV_TICK_EN
  logic [NUM_CH-1:0] tick_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= rise;
  end

  assign bus.tick = tick_q;
`endif
endmodule

// File: tb/tb_gpu_clock_divider_multi.sv
// Randomized and directed checks of gpu_clock_divider_multi against a period-level reference model.
module tb_gpu_clock_divider_multi;
  localparam int NUM_CH      = 3;
  localparam int DIV_WIDTH   = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  gpu_clock_divider_multi_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH)) bus ();

  gpu_clock_divider_multi #(
    .NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

`ifdef GPU_CLKDIV_TICK_EN
  localparam int OW = 3*NUM_CH + 1;
  wire [OW-1:0] obs = {bus.tick, bus.clk_out, bus.div_pending, bus.wr_err};
`else
  localparam int OW = 2*NUM_CH + 1;
  wire [OW-1:0] obs = {bus.clk_out, bus.div_pending, bus.wr_err};
`endif

  // Reference model: position within the current period, active divisor, queued divisor.
  bit m_act  [NUM_CH];
  int m_pos  [NUM_CH];
  int m_d    [NUM_CH];
  int m_pend [NUM_CH];
  bit m_has  [NUM_CH];
  bit m_err;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_pos[c] = 0; m_d[c] = DEFAULT_DIV; m_pend[c] = 0; m_has[c] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_step();
    bit valid;
    bit hit;
    valid = bus.wr_en && (int'(bus.wr_div) >= 2) && (int'(bus.wr_ch) < NUM_CH);
    m_err = bus.wr_en && !valid;
    for (int c = 0; c < NUM_CH; c++) begin
      hit = valid && (int'(bus.wr_ch) == c);
      if (!m_act[c]) begin
        if (hit) m_d[c] = int'(bus.wr_div);
        if (bus.ch_en[c]) begin m_act[c] = 1; m_pos[c] = 0; end
      end else if (m_pos[c] == m_d[c] - 1) begin
        if (m_has[c]) m_d[c] = m_pend[c];
        m_has[c] = 0;
        if (hit) m_d[c] = int'(bus.wr_div);
        m_pos[c] = 0;
        m_act[c] = bus.ch_en[c];
      end else begin
        m_pos[c]++;
        if (hit) begin m_pend[c] = int'(bus.wr_div); m_has[c] = 1; end
      end
    end
  endtask

  function automatic logic [OW-1:0] model_vec();
    logic [NUM_CH-1:0] ck, pd, tk;
    for (int c = 0; c < NUM_CH; c++) begin
      ck[c] = m_act[c] && (m_pos[c] >= (m_d[c] >> 1));
      tk[c] = m_act[c] && (m_pos[c] == (m_d[c] >> 1));
      pd[c] = m_has[c];
    end
`ifdef GPU_CLKDIV_TICK_EN
    return {tk, ck, pd, m_err};
`else
    return {ck, pd, m_err};
`endif
  endfunction

  task automatic advance();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    bus.ch_en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    total++; if (bus.clk_out !== 3'b000) begin bad++; $display("FAIL reset_clk_out got=%b want=000", bus.clk_out); end
    total++; if (bus.div_pending !== 3'b000) begin bad++; $display("FAIL reset_pending got=%b want=000", bus.div_pending); end
    total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%b want=0", bus.wr_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_default_div();
    logic [3:0] pat4 = 4'b1100;
    bus.ch_en = 3'b001;
    for (int k = 0; k < 12; k++) begin
      advance();
      total++; if (bus.clk_out[0] !== pat4[k%4]) begin bad++; $display("FAIL d4_pattern k=%0d got=%b want=%b", k, bus.clk_out[0], pat4[k%4]); end
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL d4_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
    bus.ch_en = 3'b000;
    for (int k = 0; k < 6; k++) begin
      advance();
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL d4_stop k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
  endtask

  task automatic test_odd_div();
    logic [4:0] pat5 = 5'b11100;
    bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_div = 8'd5;
    advance();
    bus.wr_en = 1'b0;
    bus.ch_en = 3'b010;
    for (int k = 0; k < 15; k++) begin
      advance();
      total++; if (bus.clk_out[1] !== pat5[k%5]) begin bad++; $display("FAIL d5_pattern k=%0d got=%b want=%b", k, bus.clk_out[1], pat5[k%5]); end
`ifdef GPU_CLKDIV_TICK_EN
      total++; if (bus.tick[1] !== (k%5 == 2)) begin bad++; $display("FAIL d5_tick k=%0d got=%b want=%b", k, bus.tick[1], (k%5 == 2)); end
`endif
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL d5_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
    bus.ch_en = 3'b000;
    repeat (6) advance();
  endtask

  task automatic test_pending();
    logic [7:0] seq = 8'b11100011;
    bus.ch_en = 3'b001;
    repeat (2) advance();
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 8'd6;
    for (int k = 0; k < 8; k++) begin
      advance();
      bus.wr_en = 1'b0;
      total++; if (bus.clk_out[0] !== seq[k]) begin bad++; $display("FAIL pend_clk k=%0d got=%b want=%b", k, bus.clk_out[0], seq[k]); end
      total++; if (bus.div_pending[0] !== (k < 2)) begin bad++; $display("FAIL pend_flag k=%0d got=%b want=%b", k, bus.div_pending[0], (k < 2)); end
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL pend_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
  endtask

  task automatic test_wr_err();
    bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_div = 8'd1;
    advance();
    total++; if (bus.wr_err !== 1'b1) begin bad++; $display("FAIL err_div got=%b want=1", bus.wr_err); end
    bus.wr_ch = 2'd3; bus.wr_div = 8'd7;
    advance();
    total++; if (bus.wr_err !== 1'b1) begin bad++; $display("FAIL err_ch got=%b want=1", bus.wr_err); end
    bus.wr_en = 1'b0;
    advance();
    total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.wr_err); end
    total++; if (bus.div_pending !== 3'b000) begin bad++; $display("FAIL err_pending got=%b want=000", bus.div_pending); end
    for (int k = 0; k < 12; k++) begin
      advance();
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL err_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
  endtask

  task automatic test_stop();
    logic [9:0] stop_pat = 10'b0000011100;
    logic [5:0] pat6 = 6'b111000;
    int guard = 0;
    while (!(m_act[0] && m_pos[0] == 0) && guard < 20) begin advance(); guard++; end
    total++; if (guard >= 20) begin bad++; $display("FAIL stop_sync got=timeout want=count0"); end
    bus.ch_en = 3'b000;
    for (int k = 0; k < 10; k++) begin
      advance();
      total++; if (bus.clk_out[0] !== stop_pat[k]) begin bad++; $display("FAIL stop_clk k=%0d got=%b want=%b", k, bus.clk_out[0], stop_pat[k]); end
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL stop_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
    bus.ch_en = 3'b001;
    for (int k = 0; k < 12; k++) begin
      advance();
      total++; if (bus.clk_out[0] !== pat6[k%6]) begin bad++; $display("FAIL restart_clk k=%0d got=%b want=%b", k, bus.clk_out[0], pat6[k%6]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pat4 = 4'b1100;
    int guard = 0;
    while (m_pos[0] != 3 && guard < 20) begin advance(); guard++; end
    total++; if (guard >= 20) begin bad++; $display("FAIL rmid_sync got=timeout want=high_phase"); end
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 8'd9;
    advance();
    bus.wr_en = 1'b0;
    total++; if (obs !== model_vec()) begin bad++; $display("FAIL rmid_pre got=%h want=%h", obs, model_vec()); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.clk_out !== 3'b000) begin bad++; $display("FAIL rmid_clk got=%b want=000", bus.clk_out); end
    total++; if (bus.div_pending !== 3'b000) begin bad++; $display("FAIL rmid_pending got=%b want=000", bus.div_pending); end
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      advance();
      total++; if (bus.clk_out[0] !== pat4[k%4]) begin bad++; $display("FAIL rmid_div k=%0d got=%b want=%b", k, bus.clk_out[0], pat4[k%4]); end
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL rmid_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    while (m_pos[0] != 0 && guard < 20) begin advance(); guard++; end
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 8'd8;
    advance();
    bus.wr_div = 8'd3;
    advance();
    bus.wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      advance();
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL b2b_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
  endtask

  task automatic test_random();
    int idx;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, NUM_CH-1));
        bus.ch_en[idx] = ~bus.ch_en[idx];
      end
      bus.wr_en = ($urandom_range(0, 3) == 0);
      bus.wr_ch = CH_W'($urandom_range(0, 3));
      bus.wr_div = ($urandom_range(0, 9) == 0) ? DIV_WIDTH'($urandom_range(0, 255))
                                               : DIV_WIDTH'($urandom_range(0, 12));
      advance();
      total++; if (obs !== model_vec()) begin bad++; $display("FAIL rand_model k=%0d got=%h want=%h", k, obs, model_vec()); end
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_odd_div();
    test_pending();
    test_wr_err();
    test_stop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
